arbitru_inmultire: RTL
======================

ARBITRU_INMULTIRE -- requirements
Module: arbitru_inmultire

Interface
REQ-001 SHALL have parameter: x, 8, operand width in bits; product width is 2*x.
REQ-002 SHALL have one clock; reset is synchronous and active-high.
REQ-003 SHALL have ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- req0, req1  input  1 each  requester 0/1 request level.
- OpA0, OpB0, OpA1, OpB1  input  x each  requester operands.
- gnt0, gnt1  output  1 each  one-cycle pulse: operands captured.
- done0, done1  output  1 each  one-cycle pulse: product valid on rez.
- rez  output  2*x  product for the requester flagged by done0/done1.
- start  output  1  one-cycle start pulse to the multiplier control path.
- OpA, OpB  output  x each  operands driven to the multiplier datapath.
- ready  input  1  multiplier finished; product valid on mul.
- mul  input  2*x  multiplier product.
- busy  output  1  high in every state except IDLE.

Function
REQ-004 SHALL implement FSM states IDLE, ISSUE, WAIT, DONE.
REQ-005 In IDLE with any req high, SHALL select one requester, latch its OpA/OpB into internal registers, pulse its gnt for that cycle, and go to ISSUE next cycle.
REQ-006 In ISSUE, SHALL assert start for exactly one cycle with OpA/OpB driven from latched registers, then go to WAIT.
REQ-007 OpA/OpB SHALL stay stable from ISSUE until leaving WAIT.
REQ-008 In WAIT, SHALL ignore ready in the first WAIT cycle (stale ready from a prior op); from the second WAIT cycle on, ready high SHALL capture mul into rez and go to DONE.
REQ-009 In DONE, SHALL pulse done of the granted requester for one cycle, then return to IDLE.
REQ-010 rez SHALL hold its value until the next capture.
REQ-011 Each operation SHALL take a minimum of 4 cycles from gnt to done; latency = 3 + multiplier cycles.
REQ-012 Requesters SHALL hold req and operands until their gnt; after gnt, operand changes SHALL NOT affect the running operation.
REQ-013 A request arriving while busy SHALL wait; arbitration occurs only in IDLE.
REQ-014 A req still high in the IDLE cycle after its own done SHALL be treated as a new request.
REQ-015 gnt0/gnt1 SHALL never be high together; done0/done1 SHALL never be high together.
REQ-016 start SHALL be asserted only in ISSUE.
REQ-017 Product SHALL be the full 2*x-bit unsigned value from mul, with no truncation.

Reset
REQ-018 reset high at a clock edge SHALL force IDLE from any state, including mid-WAIT, aborting the operation without a done pulse.
REQ-019 On reset, SHALL clear to 0: gnt0, gnt1, done0, done1, start, busy, rez, OpA, OpB, and the latched-operand registers.
REQ-020 On reset, SHALL set the round-robin pointer (when compiled in) to favour requester 0.

Configuration
REQ-021 With macro ARB_ROUND_ROBIN_EN defined, simultaneous requests SHALL be granted alternately, and the last-granted requester loses the next tie.
REQ-022 Without ARB_ROUND_ROBIN_EN, SHALL use fixed priority: requester 0 always wins a tie, and no pointer register exists.
REQ-023 A single requester SHALL always be granted immediately in both modes.

Verification
REQ-024 x=8: req0 alone, 12*13 -> gnt0 pulse, start one cycle later, done0 with rez=156, done1 never high.
REQ-025 req1 alone, 255*255 -> done1 with rez=65025.
REQ-026 req0 and req1 held high together, ops 3*4 and 5*6, with macro defined -> order 0,1,0,1 with rez 12, 30 alternating; without the macro -> requester 0 only, and req1 starves until req0 drops.
REQ-027 reset asserted during WAIT of 7*9 -> next cycle busy=0, rez=0, no done; a subsequent 2*2 returns rez=4.
REQ-028 ready held high from a prior op when start issues for 10*10 -> first WAIT cycle ignores ready; rez=100 only after ready is sampled from the second WAIT cycle on.
REQ-029 Operands OpA0 changed 1 cycle after gnt0 (6*7 then 0) -> rez=42.

Source files
------------

// File: rtl/arbitru_inmultire.sv
// arbitru_inmultire: two-requester arbiter sharing one multiplier, tie-break by fixed priority or,
// with ARB_ROUND_ROBIN_EN defined, alternating round-robin
module arbitru_inmultire #(
  parameter int x = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           req0,
  input  logic           req1,
  input  logic [x-1:0]   OpA0,
  input  logic [x-1:0]   OpB0,
  input  logic [x-1:0]   OpA1,
  input  logic [x-1:0]   OpB1,
  output logic           gnt0,
  output logic           gnt1,
  output logic           done0,
  output logic           done1,
  output logic [2*x-1:0] rez,
  output logic           start,
  output logic [x-1:0]   OpA,
  output logic [x-1:0]   OpB,
  input  logic           ready,
  input  logic [2*x-1:0] mul,
  output logic           busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} stateT;
  stateT state;
  logic owner, waitFirst, pick1, grant;
`ifdef ARB_ROUND_ROBIN_EN
  logic favour1;
  assign pick1 = req1 & (~req0 | favour1);
`else
  assign pick1 = req1 & ~req0;
`endif
  // grant is decided in the IDLE cycle itself so the operands are latched on that edge
  assign grant = state == IDLE & (req0 | req1) & ~reset;
  assign gnt0 = grant & ~pick1;
  assign gnt1 = grant & pick1;
  always_ff @(posedge clk) begin
    start <= 1'b0;
    done0 <= 1'b0;
    done1 <= 1'b0;
    if (reset) begin
      state <= IDLE;
      busy <= 1'b0;
      rez <= '0;
      OpA <= '0;
      OpB <= '0;
      owner <= 1'b0;
      waitFirst <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      favour1 <= 1'b0;
`endif
    end else case (state)
      IDLE: if (grant) begin
        state <= ISSUE;
        busy <= 1'b1;
        start <= 1'b1;
        owner <= pick1;
        OpA <= pick1 ? OpA1 : OpA0;
        OpB <= pick1 ? OpB1 : OpB0;
`ifdef ARB_ROUND_ROBIN_EN
        favour1 <= ~pick1;
`endif
      end
      ISSUE: begin
        state <= WAIT;
        waitFirst <= 1'b1;
      end
      // ready seen in the first WAIT cycle may still belong to the previous product
      WAIT: begin
        waitFirst <= 1'b0;
        if (ready & ~waitFirst) begin
          state <= DONE;
          rez <= mul;
          done0 <= ~owner;
          done1 <= owner;
        end
      end
      DONE: begin
        state <= IDLE;
        busy <= 1'b0;
      end
      default: state <= IDLE;
    endcase
  end
endmodule
